timer_dev: RTL

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev_pkg.sv | 34 +++
 rtl/timer_dev.sv | 96 +++++++++
 2 files changed

// File: rtl/timer_dev_pkg.sv
// Shared register map, CTRL bit layout, mode and state encodings for the
// timer block and the bus bridge that decodes its word address.
package timer_dev_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_AUTO    = 2'b01,
    MODE_RSVD2   = 2'b10,
    MODE_RSVD3   = 2'b11
  } timer_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Only the auto-reload encoding reloads; every other mode acts as one-shot.
  function automatic logic mode_is_auto(input logic [1:0] mode);
    return mode == MODE_AUTO;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Down-counting timer with CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation and a maskable registered interrupt.
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:2]  Add,
  input  logic        We,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  logic [3:0]   ctrl;
  logic [31:0]  preset;
  logic [31:0]  count;
  logic         pending;
  logic         irq;
  timer_state_e state;

  logic wr_ctrl;
  logic wr_preset;
  logic set_pending;

  assign wr_ctrl   = We && (Add == ADDR_CTRL);
  assign wr_preset = We && (Add == ADDR_PRESET);

  // Terminal count is reached while still enabled in CNT.
  assign set_pending = (state == ST_CNT) && ctrl[CTRL_EN] && (count <= 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= 4'd0;
      preset  <= 32'd0;
      count   <= 32'd0;
      pending <= 1'b0;
      irq     <= 1'b0;
      state   <= ST_IDLE;
    end else begin
      if (wr_preset) preset <= WD;

      // Setting wins over a CPU clear on the same edge so no interrupt is lost.
      if (set_pending)               pending <= 1'b1;
      else if (wr_ctrl || wr_preset) pending <= 1'b0;

      irq <= ctrl[CTRL_IM] & pending;

      case (state)
        ST_IDLE: begin
          if (ctrl[CTRL_EN]) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'd0;
            state <= ST_INT;
          end
        end
        ST_INT: begin
          if (mode_is_auto(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
            state <= ctrl[CTRL_EN] ? ST_LOAD : ST_IDLE;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed last so a CPU write to CTRL overrides the hardware Enable clear.
      if (wr_ctrl) ctrl <= WD[3:0];
    end
  end

  always_comb begin
    RD = 32'd0;
    case (Add)
      ADDR_CTRL:   RD = {28'd0, ctrl};
      ADDR_PRESET: RD = preset;
      ADDR_COUNT:  RD = count;
      ADDR_RSVD:   RD = 32'd0;
      default:     RD = 32'd0;
    endcase
  end

  assign IRQ = irq;

endmodule
